// File: rtl/float_round_arbiter.sv
// float_round_arbiter: round-robin sharing of one float_rounder among R requesters,
// with dynamic rounding-mode resolution, a registered result slot and an inexact counter.
module float_rounder #(
    parameter int N = 4
) (
    input  logic         i_sign,
    input  logic [N-1:0] i_a,
    input  logic [1:0]   i_gs,
    input  logic [2:0]   i_mode,
    output logic [N:0]   o_y,
    output logic         o_inexact,
    output logic         o_invalid
);
    logic w_up;
    always_comb begin
        w_up = 1'b0;
        case (i_mode)
            3'd0:    w_up = i_gs[1] & (i_gs[0] | i_a[0]);
            3'd2:    w_up = |i_gs & i_sign;
            3'd3:    w_up = |i_gs & ~i_sign;
            3'd4:    w_up = i_gs[1];
            default: w_up = 1'b0;
        endcase
    end
    assign o_invalid = i_mode > 3'd4;
    assign o_inexact = ~o_invalid & |i_gs;
    assign o_y       = o_invalid ? '0 : {1'b0, i_a} + (N+1)'(w_up);
endmodule

module float_round_arbiter #(
    parameter int N = 4,
    parameter int R = 3,
    localparam int IW = $clog2(R)
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [2:0]     frm,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R-1:0]   req_sign,
    input  logic [R*N-1:0] req_A,
    input  logic [2*R-1:0] req_sticky,
    input  logic [3*R-1:0] req_mode,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [IW-1:0]  resp_id,
    output logic [N:0]     resp_Y,
    output logic           resp_inexact,
    output logic           resp_invalid,
    output logic           resp_carry,
    input  logic           clear_cnt,
    output logic [15:0]    inexact_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_ptr, r_id, w_gnt, w_hi_idx, w_lo_idx;
    logic          w_hi_any, w_lo_any, w_can_accept, w_accept;
    logic          w_sign;
    logic [N-1:0]  w_a;
    logic [1:0]    w_gs;
    logic [2:0]    w_req_mode, w_mode;
    logic [N:0]    w_y, r_y;
    logic          w_inexact, w_invalid, r_inexact, r_invalid;
    logic [15:0]   r_cnt;

    // Descending scan leaves the lowest matching index; hi = at/after ptr, lo = wrap-around.
    always_comb begin
        w_hi_any = 1'b0;
        w_hi_idx = '0;
        w_lo_any = 1'b0;
        w_lo_idx = '0;
        for (int i = R - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_lo_any = 1'b1;
                w_lo_idx = IW'(i);
                if (IW'(i) >= r_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = IW'(i);
                end
            end
        end
        w_gnt = w_hi_any ? w_hi_idx : w_lo_idx;
    end

    assign w_can_accept = (r_state == EMPTY) | resp_ready;
    assign w_accept     = w_lo_any & w_can_accept;

    always_comb begin
        w_sign     = 1'b0;
        w_a        = '0;
        w_gs       = '0;
        w_req_mode = '0;
        req_ready  = '0;
        for (int i = 0; i < R; i++) begin
            if (IW'(i) == w_gnt) begin
                w_sign       = req_sign[i];
                w_a          = req_A[i*N +: N];
                w_gs         = req_sticky[2*i +: 2];
                w_req_mode   = req_mode[3*i +: 3];
                req_ready[i] = w_accept;
            end
        end
    end

    assign w_mode = (w_req_mode == 3'd7) ? frm : w_req_mode;

    float_rounder #(.N(N)) u_rounder (
        .i_sign    (w_sign),
        .i_a       (w_a),
        .i_gs      (w_gs),
        .i_mode    (w_mode),
        .o_y       (w_y),
        .o_inexact (w_inexact),
        .o_invalid (w_invalid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= EMPTY;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)        w_state_nxt = FULL;
        else if (resp_ready) w_state_nxt = EMPTY;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_y       <= '0;
            r_inexact <= 1'b0;
            r_invalid <= 1'b0;
        end else if (w_accept) begin
            r_ptr     <= (w_gnt == IW'(R - 1)) ? '0 : w_gnt + IW'(1);
            r_id      <= w_gnt;
            r_y       <= w_y;
            r_inexact <= w_inexact;
            r_invalid <= w_invalid;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                              r_cnt <= '0;
        else if (clear_cnt)                        r_cnt <= '0;
        else if (w_accept & w_inexact & ~&r_cnt)   r_cnt <= r_cnt + 16'd1;
    end

    assign resp_valid   = r_state == FULL;
    assign resp_id      = r_id;
    assign resp_Y       = r_y;
    assign resp_inexact = r_inexact;
    assign resp_invalid = r_invalid;
    assign resp_carry   = r_y[N];
    assign inexact_cnt  = r_cnt;
endmodule

// File: tb/tb_float_round_arbiter.sv
// tb_float_round_arbiter: directed and randomized checks of rounding, arbitration,
// backpressure, counter saturation and reset against a spec-level reference model.
module tb_float_round_arbiter;
    localparam int N = 4;
    localparam int R = 3;
    localparam int IW = 2;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [2:0]     frm;
    logic [R-1:0]   req_valid, req_ready, req_sign;
    logic [R*N-1:0] req_A;
    logic [2*R-1:0] req_sticky;
    logic [3*R-1:0] req_mode;
    logic           resp_valid, resp_ready;
    logic [IW-1:0]  resp_id;
    logic [N:0]     resp_Y;
    logic           resp_inexact, resp_invalid, resp_carry, clear_cnt;
    logic [15:0]    inexact_cnt;
    int             n_cmp = 0;
    int             n_bad = 0;

    float_round_arbiter #(.N(N), .R(R)) dut (
        .clock(clock), .reset_n(reset_n), .frm(frm),
        .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
        .req_A(req_A), .req_sticky(req_sticky), .req_mode(req_mode),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_Y(resp_Y), .resp_inexact(resp_inexact), .resp_invalid(resp_invalid),
        .resp_carry(resp_carry), .clear_cnt(clear_cnt), .inexact_cnt(inexact_cnt)
    );

    always #5 clock = ~clock;

    // Result as {invalid, inexact, Y}; gs read as the fraction gs/4 of one ulp.
    function automatic logic [N+2:0] ref_round(input logic sgn, input int a, input int gs, input int md, input int f);
        int m;
        int q;
        bit up;
        m = (md == 7) ? f : md;
        if (m > 4) return {1'b1, 1'b0, (N+1)'(0)};
        case (m)
            0:       up = (gs > 2) || (gs == 2 && (a % 2) == 1);
            1:       up = 0;
            2:       up = (gs != 0) && sgn;
            3:       up = (gs != 0) && !sgn;
            default: up = gs >= 2;
        endcase
        q = a + (up ? 1 : 0);
        return {1'b0, gs != 0, (N+1)'(q)};
    endfunction

    task automatic set_req(input int i, input logic sgn, input int a, input int gs, input int md);
        req_sign[i] = sgn;
        req_A[i*N +: N] = N'(a);
        req_sticky[2*i +: 2] = 2'(gs);
        req_mode[3*i +: 3] = 3'(md);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0h want 0", resp_valid); end
        n_cmp++; if (resp_id !== '0) begin n_bad++; $display("FAIL reset_id got %0h want 0", resp_id); end
        n_cmp++; if (resp_Y !== '0) begin n_bad++; $display("FAIL reset_y got %0h want 0", resp_Y); end
        n_cmp++; if ({resp_inexact, resp_invalid, resp_carry} !== 3'b0) begin n_bad++; $display("FAIL reset_flags got %b want 000", {resp_inexact, resp_invalid, resp_carry}); end
        n_cmp++; if (inexact_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0h want 0", inexact_cnt); end
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic round_one(input string nm, input int idx, input logic sgn, input int a, input int gs,
                             input int md, input int f, input int ey, input logic einv, input logic einx);
        resp_ready = 1'b1;
        frm = 3'(f);
        set_req(idx, sgn, a, gs, md);
        req_valid = '0;
        req_valid[idx] = 1'b1;
        @(posedge clock); #1;
        req_valid = '0;
        frm = 3'(~f);
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL %s valid got %0h want 1", nm, resp_valid); end
        n_cmp++; if (resp_id !== IW'(idx)) begin n_bad++; $display("FAIL %s id got %0d want %0d", nm, resp_id, idx); end
        n_cmp++; if (resp_Y !== (N+1)'(ey)) begin n_bad++; $display("FAIL %s y got %b want %b", nm, resp_Y, (N+1)'(ey)); end
        n_cmp++; if (resp_invalid !== einv) begin n_bad++; $display("FAIL %s invalid got %0h want %0h", nm, resp_invalid, einv); end
        n_cmp++; if (resp_inexact !== einx) begin n_bad++; $display("FAIL %s inexact got %0h want %0h", nm, resp_inexact, einx); end
        n_cmp++; if (resp_carry !== ((ey >> N) & 1)) begin n_bad++; $display("FAIL %s carry got %0h want %0h", nm, resp_carry, (ey >> N) & 1); end
        @(posedge clock); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL %s drain got %0h want 0", nm, resp_valid); end
    endtask

    task automatic test_rounding;
        round_one("rne_tie_odd",  0, 0, 4'b0101, 2, 0, 0, 5'b00110, 0, 1);
        round_one("rne_tie_even", 1, 0, 4'b0100, 2, 0, 0, 5'b00100, 0, 1);
        round_one("rne_carry",    2, 0, 4'b1111, 3, 0, 0, 5'b10000, 0, 1);
        round_one("rdn_neg",      0, 1, 3, 1, 2, 0, 4, 0, 1);
        round_one("rup_neg",      1, 1, 3, 1, 3, 0, 3, 0, 1);
        round_one("rtz",          2, 0, 9, 3, 1, 0, 9, 0, 1);
        round_one("rmm",          0, 0, 2, 2, 4, 0, 3, 0, 1);
        round_one("dyn_rup",      1, 0, 2, 1, 7, 3, 3, 0, 1);
        round_one("reserved5",    2, 0, 6, 3, 5, 0, 0, 1, 0);
        round_one("dyn_frm7",     0, 0, 6, 3, 7, 7, 0, 1, 0);
    endtask

    task automatic test_arbitration;
        int exp_a[6] = '{0, 1, 2, 0, 1, 2};
        int exp_b[4] = '{0, 2, 0, 2};
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < R; i++) set_req(i, 0, i + 1, 0, 1);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            n_cmp++; if (resp_id !== IW'(exp_a[k]) || resp_valid !== 1'b1) begin n_bad++; $display("FAIL arb_all[%0d] id got %0d want %0d", k, resp_id, exp_a[k]); end
        end
        req_valid = 3'b101;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            n_cmp++; if (resp_id !== IW'(exp_b[k]) || resp_valid !== 1'b1) begin n_bad++; $display("FAIL arb_drop1[%0d] id got %0d want %0d", k, resp_id, exp_b[k]); end
        end
        req_valid = '0;
        @(posedge clock); #1;
    endtask

    task automatic test_backpressure;
        resp_ready = 1'b0;
        set_req(0, 0, 7, 0, 1);
        req_valid = 3'b001;
        @(posedge clock); #1;
        n_cmp++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_Y !== 5'd7) begin n_bad++; $display("FAIL bp_fill got v%0h id%0d y%0d want v1 id0 y7", resp_valid, resp_id, resp_Y); end
        for (int i = 0; i < R; i++) set_req(i, 0, 10 + i, 0, 1);
        req_valid = 3'b111;
        repeat (5) begin
            #1;
            n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL bp_ready got %b want 000", req_ready); end
            @(posedge clock); #1;
            n_cmp++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_Y !== 5'd7) begin n_bad++; $display("FAIL bp_hold got v%0h id%0d y%0d want v1 id0 y7", resp_valid, resp_id, resp_Y); end
        end
        resp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL bp_release_ready got %b want 010", req_ready); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock); #1;
            n_cmp++; if (resp_id !== IW'(k % R) || resp_Y !== (N+1)'(10 + k % R)) begin n_bad++; $display("FAIL bp_order[%0d] got id%0d y%0d want id%0d y%0d", k, resp_id, resp_Y, k % R, 10 + k % R); end
        end
        req_valid = '0;
        @(posedge clock); #1;
    endtask

    task automatic test_counter;
        int seq[5] = '{1, 3, 0, 2, 0};
        do_reset();
        resp_ready = 1'b1;
        set_req(0, 0, 5, 0, 1);
        req_valid = 3'b001;
        for (int k = 0; k < 5; k++) begin
            req_sticky[1:0] = 2'(seq[k]);
            @(posedge clock); #1;
        end
        req_valid = '0;
        n_cmp++; if (inexact_cnt !== 16'd3) begin n_bad++; $display("FAIL cnt_three got %0d want 3", inexact_cnt); end
        clear_cnt = 1'b1;
        @(posedge clock); #1;
        clear_cnt = 1'b0;
        n_cmp++; if (inexact_cnt !== 16'd0) begin n_bad++; $display("FAIL cnt_clear got %0d want 0", inexact_cnt); end
        req_sticky[1:0] = 2'b01;
        req_valid = 3'b001;
        repeat (65535) @(posedge clock);
        #1;
        n_cmp++; if (inexact_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL cnt_full got %0h want ffff", inexact_cnt); end
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (inexact_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL cnt_sat got %0h want ffff", inexact_cnt); end
        req_valid = '0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid;
        resp_ready = 1'b0;
        set_req(1, 0, 9, 1, 1);
        req_valid = 3'b010;
        @(posedge clock); #1;
        req_valid = '0;
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_fill got %0h want 1", resp_valid); end
        #3;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (resp_valid !== 1'b0 || resp_Y !== '0 || inexact_cnt !== 16'd0) begin n_bad++; $display("FAIL rstmid_clear got v%0h y%0h cnt%0h want 0 0 0", resp_valid, resp_Y, inexact_cnt); end
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < R; i++) set_req(i, 0, i, 0, 1);
        req_valid = 3'b111;
        resp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL rstmid_ptr_ready got %b want 001", req_ready); end
        @(posedge clock); #1;
        n_cmp++; if (resp_id !== 2'd0) begin n_bad++; $display("FAIL rstmid_ptr_id got %0d want 0", resp_id); end
        req_valid = '0;
        @(posedge clock); #1;
    endtask

    task automatic test_random;
        int g;
        int m_ptr = 0;
        int m_id = 0;
        int m_cnt = 0;
        bit m_full = 0;
        bit acc;
        logic [N+2:0] m_res = '0;
        logic [N+2:0] r = '0;
        logic [R-1:0] exp_rdy;
        do_reset();
        repeat (400) begin
            req_valid  = R'($urandom);
            req_sign   = R'($urandom);
            req_A      = (R*N)'($urandom);
            req_sticky = (2*R)'($urandom);
            req_mode   = (3*R)'($urandom);
            frm        = 3'($urandom);
            resp_ready = $urandom_range(3) != 0;
            clear_cnt  = $urandom_range(15) == 0;
            #1;
            g = -1;
            for (int k = 0; k < R; k++) if (g < 0 && req_valid[(m_ptr + k) % R]) g = (m_ptr + k) % R;
            acc = (g >= 0) && (!m_full || resp_ready);
            exp_rdy = '0;
            if (acc) begin
                exp_rdy[g] = 1'b1;
                r = ref_round(req_sign[g], int'(req_A[g*N +: N]), int'(req_sticky[2*g +: 2]), int'(req_mode[3*g +: 3]), int'(frm));
            end
            n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_ready got %b want %b", req_ready, exp_rdy); end
            @(posedge clock); #1;
            if (clear_cnt) m_cnt = 0;
            else if (acc && r[N+1] && m_cnt < 65535) m_cnt++;
            if (acc) begin
                m_res = r;
                m_id = g;
                m_ptr = (g + 1) % R;
            end
            m_full = acc || (m_full && !resp_ready);
            n_cmp++; if (resp_valid !== m_full) begin n_bad++; $display("FAIL rnd_valid got %0h want %0h", resp_valid, m_full); end
            if (m_full) begin
                n_cmp++; if ({resp_invalid, resp_inexact, resp_Y} !== m_res || resp_id !== IW'(m_id) || resp_carry !== m_res[N]) begin
                    n_bad++; $display("FAIL rnd_data got id%0d {inv,inx,y}=%b c%0h want id%0d %b c%0h", resp_id, {resp_invalid, resp_inexact, resp_Y}, resp_carry, m_id, m_res, m_res[N]);
                end
            end
            n_cmp++; if (inexact_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt got %0d want %0d", inexact_cnt, m_cnt); end
        end
        clear_cnt = 1'b0;
        req_valid = '0;
        resp_ready = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        frm = 3'd0;
        req_valid = '0;
        req_sign = '0;
        req_A = '0;
        req_sticky = '0;
        req_mode = '0;
        resp_ready = 1'b1;
        clear_cnt = 1'b0;
        test_reset();
        test_rounding();
        test_arbitration();
        test_backpressure();
        test_counter();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
